// File: rtl/quad_gate_tester_pkg.sv
// Shared types and constants for the quad AND gate tester.
// States, widths and the reference gate function.
package quad_gate_tester_pkg;

  localparam int VEC_W = 8;
  localparam int CNT_W = 9;
  localparam int CH_N = 4;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  function automatic logic [CH_N-1:0] and_expect(
    input logic [CH_N-1:0] a,
    input logic [CH_N-1:0] b
  );
    return a & b;
  endfunction

endpackage

// File: rtl/gate_test_settle_timer.sv
// Loadable down-counter pacing the settle window.
// zero flags the cycle in which the count runs out.
module gate_test_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The count reaches zero on the coming edge.
  assign zero = (cnt <= W'(1));

endmodule

// File: rtl/quad_and_gate_tester.sv
// Exhaustive 256-vector sequencer for a quad 2-input AND gate.
// QUAD_GATE_TESTER_SYNC_EN adds a 2-flop dut_y synchronizer.
module quad_and_gate_tester
  import quad_gate_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [CH_N-1:0]  dut_a,
  output logic [CH_N-1:0]  dut_b,
  input  logic [CH_N-1:0]  dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CH_N-1:0]  fail_mask,
  output logic [CNT_W-1:0] fail_count,
  output logic [VEC_W-1:0] first_fail_vec
);

`ifdef QUAD_GATE_TESTER_SYNC_EN
  localparam int SETTLE_EFF = SETTLE_CYCLES + SYNC_STAGES;
  localparam int TMR_W = 5;
`else
  localparam int SETTLE_EFF = SETTLE_CYCLES;
  localparam int TMR_W = 4;
`endif

  localparam logic [TMR_W-1:0] SETTLE_LD =
    TMR_W'(SETTLE_EFF);
  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  state_t state;
  state_t state_nxt;

  logic [VEC_W-1:0] vec;
  logic [CH_N-1:0]  y_cmp;
  logic [CH_N-1:0]  diff;
  logic             miss;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tmr_zero;
  logic             idle_or_done;

`ifdef QUAD_GATE_TESTER_SYNC_EN
  logic [CH_N-1:0] y_s1;
  logic [CH_N-1:0] y_s2;

  // Resynchronize the external gate outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s1 <= '0;
      y_s2 <= '0;
    end else begin
      y_s1 <= dut_y;
      y_s2 <= y_s1;
    end
  end

  assign y_cmp = y_s2;
`else
  assign y_cmp = dut_y;
`endif

  assign diff = y_cmp ^ and_expect(dut_a, dut_b);
  assign miss = (diff != '0);
  assign cnt_nxt = fail_count + CNT_W'(miss);
  assign idle_or_done = (state == IDLE) ||
                        (state == DONE);

  gate_test_settle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == APPLY),
    .load_val (SETTLE_LD),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) state_nxt = APPLY;
        end
        APPLY: begin
          state_nxt = (SETTLE_EFF == 0) ?
                      CHECK : SETTLE;
        end
        SETTLE: begin
          if (tmr_zero) state_nxt = CHECK;
        end
        CHECK: begin
          state_nxt = (vec == VEC_LAST) ?
                      DONE : APPLY;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == APPLY),
      (state == SETTLE),
      (state == CHECK): busy = 1'b1;
      (state == DONE):  done = 1'b1;
      default: ;
    endcase
  end

  // Vector drive, result accumulation and pass flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      dut_a          <= '0;
      dut_b          <= '0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else if (abort) begin
      if (state != IDLE) begin
        vec   <= '0;
        dut_a <= '0;
        dut_b <= '0;
        pass  <= 1'b0;
      end
    end else begin
      if (idle_or_done && start) begin
        vec            <= '0;
        pass           <= 1'b0;
        fail_mask      <= '0;
        fail_count     <= '0;
        first_fail_vec <= '0;
      end
      if (state == APPLY) begin
        dut_a <= vec[CH_N-1:0];
        dut_b <= vec[VEC_W-1:CH_N];
      end
      if (state == CHECK) begin
        if (miss) begin
          fail_mask  <= fail_mask | diff;
          fail_count <= cnt_nxt;
          if (fail_count == '0) begin
            first_fail_vec <= vec;
          end
        end
        if (vec == VEC_LAST) begin
          pass <= (cnt_nxt == '0);
        end else begin
          vec <= vec + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_and_gate_tester.sv
// Directed bench for quad_and_gate_tester.
// Three instances (settle 2/1/3) against a faultable gate model.
module tb_quad_and_gate_tester;

`ifdef QUAD_GATE_TESTER_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int PER0 = 256 * (2 + 2 + EXTRA);
  localparam int PER1 = 256 * (1 + 2 + EXTRA);
  localparam int PER2 = 256 * (3 + 2 + EXTRA);
  localparam bit S1_FAILS = (1 + EXTRA) < 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode = 0;
  logic dly = 1'b0;

  logic [3:0] a [3];
  logic [3:0] b [3];
  logic [3:0] y [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic [3:0] mask [3];
  logic [8:0] fcnt [3];
  logic [7:0] ffv [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] model(
    input int m,
    input logic [7:0] v
  );
    logic [3:0] ai;
    logic [3:0] bi;
    ai = v[3:0];
    bi = v[7:4];
    case (m)
      1: return (ai & bi) | 4'b0100;
      2: return {ai[3:1] & bi[3:1],
                 ai[0] | bi[0]};
      default: return ai & bi;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SC = (g == 0) ? 2 :
                        ((g == 1) ? 1 : 3);
    logic [7:0] p0, p1, p2;
    logic [7:0] sel;

    always @(posedge clk) begin
      p0 <= {b[g], a[g]};
      p1 <= p0;
      p2 <= p1;
    end

    always_comb begin
      sel = dly ? p2 : {b[g], a[g]};
      y[g] = model(mode, sel);
    end

    quad_and_gate_tester #(
      .SETTLE_CYCLES(SC)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .dut_a          (a[g]),
      .dut_b          (b[g]),
      .dut_y          (y[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .fail_mask      (mask[g]),
      .fail_count     (fcnt[g]),
      .first_fail_vec (ffv[g])
    );
  end

  task automatic run_all(
    output int c0,
    output int c1,
    output int c2
  );
    int cyc;
    c0 = -1;
    c1 = -1;
    c2 = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((c0 < 0 || c1 < 0 || c2 < 0) &&
           cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (done[0] && c0 < 0) c0 = cyc;
      if (done[1] && c1 < 0) c1 = cyc;
      if (done[2] && c2 < 0) c2 = cyc;
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((busy[0] || busy[1] || busy[2]) &&
           cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 6000) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%b%b%b",
               busy[0], busy[1], busy[2]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a[0], b[0], busy[0], done[0], pass[0]}
        !== 11'd0) begin
      errors++;
      $display("FAIL reset_io got a=%h b=%h busy=%b done=%b pass=%b want 0",
               a[0], b[0], busy[0], done[0], pass[0]);
    end
    checks++;
    if ({mask[0], fcnt[0], ffv[0]} !== 21'd0) begin
      errors++;
      $display("FAIL reset_stats got mask=%b cnt=%0d ffv=%h want 0",
               mask[0], fcnt[0], ffv[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_healthy();
    int c0, c1, c2;
    mode = 0;
    dly = 1'b0;
    run_all(c0, c1, c2);
    checks++;
    if (c0 !== PER0) begin
      errors++;
      $display("FAIL healthy_latency got %0d want %0d", c0, PER0);
    end
    checks++;
    if (c1 !== PER1 || c2 !== PER2) begin
      errors++;
      $display("FAIL healthy_latency_s13 got %0d/%0d want %0d/%0d",
               c1, c2, PER1, PER2);
    end
    checks++;
    if (pass[0] !== 1'b1 || fcnt[0] !== 9'd0 ||
        mask[0] !== 4'b0000) begin
      errors++;
      $display("FAIL healthy_result got pass=%b cnt=%0d mask=%b want 1/0/0000",
               pass[0], fcnt[0], mask[0]);
    end
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b1) begin
      errors++;
      $display("FAIL healthy_flags got busy=%b done=%b want 0/1",
               busy[0], done[0]);
    end
  endtask

  task automatic test_y3_stuck();
    int c0, c1, c2;
    mode = 1;
    dly = 1'b0;
    run_all(c0, c1, c2);
    checks++;
    if (mask[0] !== 4'b0100 || fcnt[0] !== 9'd192) begin
      errors++;
      $display("FAIL y3_stuck got mask=%b cnt=%0d want 0100/192",
               mask[0], fcnt[0]);
    end
    checks++;
    if (ffv[0] !== 8'h00 || pass[0] !== 1'b0) begin
      errors++;
      $display("FAIL y3_stuck_first got ffv=%h pass=%b want 00/0",
               ffv[0], pass[0]);
    end
  endtask

  task automatic test_ch1_or();
    int c0, c1, c2;
    mode = 2;
    dly = 1'b0;
    run_all(c0, c1, c2);
    checks++;
    if (mask[0] !== 4'b0001 || fcnt[0] !== 9'd128 ||
        ffv[0] !== 8'h01) begin
      errors++;
      $display("FAIL ch1_or got mask=%b cnt=%0d ffv=%h want 0001/128/01",
               mask[0], fcnt[0], ffv[0]);
    end
    checks++;
    if (pass[0] !== 1'b0) begin
      errors++;
      $display("FAIL ch1_or_pass got %b want 0", pass[0]);
    end
  endtask

  task automatic test_delay();
    int c0, c1, c2;
    mode = 0;
    dly = 1'b1;
    run_all(c0, c1, c2);
    checks++;
    if ((fcnt[1] != 9'd0) !== S1_FAILS) begin
      errors++;
      $display("FAIL delay_s1 got cnt=%0d want nonzero=%b",
               fcnt[1], S1_FAILS);
    end
    checks++;
    if (pass[2] !== 1'b1 || fcnt[2] !== 9'd0) begin
      errors++;
      $display("FAIL delay_s3 got pass=%b cnt=%0d want 1/0",
               pass[2], fcnt[2]);
    end
    dly = 1'b0;
  endtask

  task automatic test_abort();
    int cyc;
    int c0, c1, c2;
    mode = 1;
    dly = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ({b[0], a[0]} !== 8'd100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL abort_reach got vec=%h want 64",
               {b[0], a[0]});
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 ||
        pass[0] !== 1'b0 || a[0] !== 4'd0 ||
        b[0] !== 4'd0) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b pass=%b a=%h b=%h want 0",
               busy[0], done[0], pass[0], a[0], b[0]);
    end
    checks++;
    if (fcnt[0] !== 9'd84 || mask[0] !== 4'b0100 ||
        ffv[0] !== 8'h00) begin
      errors++;
      $display("FAIL abort_keep got cnt=%0d mask=%b ffv=%h want 84/0100/00",
               fcnt[0], mask[0], ffv[0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b want 0", busy[0]);
    end
    mode = 0;
    run_all(c0, c1, c2);
    checks++;
    if (c0 !== PER0 || pass[0] !== 1'b1 ||
        fcnt[0] !== 9'd0 || mask[0] !== 4'd0) begin
      errors++;
      $display("FAIL abort_rerun got cyc=%0d pass=%b cnt=%0d mask=%b want %0d/1/0/0",
               c0, pass[0], fcnt[0], mask[0], PER0);
    end
  endtask

  task automatic test_start_midrun();
    int cyc;
    mode = 0;
    dly = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done[0] && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 300);
    end
    start = 1'b0;
    checks++;
    if (cyc !== PER0 || pass[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_midrun got cyc=%0d pass=%b want %0d/1",
               cyc, pass[0], PER0);
    end
    wait_idle();
  endtask

  task automatic test_rst_midrun();
    mode = 1;
    dly = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    checks++;
    if (fcnt[0] === 9'd0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got cnt=%0d busy=%b want nonzero/1",
               fcnt[0], busy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a[0], b[0], busy[0], done[0], pass[0],
         mask[0], fcnt[0], ffv[0]} !== 32'd0) begin
      errors++;
      $display("FAIL rst_async got a=%h b=%h busy=%b cnt=%0d mask=%b ffv=%h want 0",
               a[0], b[0], busy[0], fcnt[0], mask[0], ffv[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_healthy();
    wait_idle();
    test_y3_stuck();
    wait_idle();
    test_ch1_or();
    wait_idle();
    test_delay();
    wait_idle();
    test_abort();
    wait_idle();
    test_start_midrun();
    test_rst_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
